// File: rtl/spi_regfile_peripheral.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// Module      : spi_regfile_peripheral
// Description : SPI Mode-0 peripheral fronting a NUM_REGS x DATA_W register
//               file. A frame is R/W bit, ADDR_W address bits, then DATA_W
//               data bits, MSB first. A frame commits on the nCS rising
//               edge only if exactly 1+ADDR_W+DATA_W bits were clocked in.
//               Frames of any other non-zero length are dropped and pulse
//               frame_err.
// Ports       : clk, rst_n      - system clock, async active-low reset
//               nCS, SCLK, COPI - SPI pins, asynchronous to clk
//               CIPO, CIPO_oe   - read data out and its drive enable
//               reg_out         - flattened registers, reg k at [k*DATA_W +: DATA_W]
//               wr_strobe       - one-cycle pulse on bit k when reg k is written
//               frame_err       - one-cycle pulse when a frame is discarded
// Options     : SPI_READBACK_EN - when defined, read frames shift register
//               contents out on CIPO; otherwise CIPO/CIPO_oe are tied low.
// Revision    : 1.0 - initial release
//============================================================================
module spi_regfile_peripheral #(
   parameter int NUM_REGS = 5,
   parameter int ADDR_W   = 7,
   parameter int DATA_W   = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       nCS,
   input  logic                       SCLK,
   input  logic                       COPI,
   output logic                       CIPO,
   output logic                       CIPO_oe,
   output logic [NUM_REGS*DATA_W-1:0] reg_out,
   output logic [NUM_REGS-1:0]        wr_strobe,
   output logic                       frame_err
);

   localparam int c_FRAME = 1 + ADDR_W + DATA_W;
   localparam int c_CNT_W = $clog2(c_FRAME + 2);
   localparam logic [c_CNT_W-1:0] c_CNT_CMD   = c_CNT_W'(1 + ADDR_W);
   localparam logic [c_CNT_W-1:0] c_CNT_FRAME = c_CNT_W'(c_FRAME);
   localparam logic [c_CNT_W-1:0] c_CNT_OVF   = c_CNT_W'(c_FRAME + 1);

   localparam logic [1:0] c_ST_IDLE = 2'd0;
   localparam logic [1:0] c_ST_CMD  = 2'd1;
   localparam logic [1:0] c_ST_DATA = 2'd2;
   localparam logic [1:0] c_ST_OVF  = 2'd3;

   // ---------------------------------------------------------------- sync
   logic r_ncs_meta, r_ncs_s, r_ncs_d;
   logic r_sclk_meta, r_sclk_s, r_sclk_d;
   logic r_copi_meta, r_copi_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // nCS path resets to "deselected" so leaving reset never looks
         // like a chip-select edge.
         r_ncs_meta  <= 1'b1;
         r_ncs_s     <= 1'b1;
         r_ncs_d     <= 1'b1;
         r_sclk_meta <= 1'b0;
         r_sclk_s    <= 1'b0;
         r_sclk_d    <= 1'b0;
         r_copi_meta <= 1'b0;
         r_copi_s    <= 1'b0;
      end else begin
         r_ncs_meta  <= nCS;
         r_ncs_s     <= r_ncs_meta;
         r_ncs_d     <= r_ncs_s;
         r_sclk_meta <= SCLK;
         r_sclk_s    <= r_sclk_meta;
         r_sclk_d    <= r_sclk_s;
         r_copi_meta <= COPI;
         r_copi_s    <= r_copi_meta;
      end
   end

   logic w_sclk_rise, w_ncs_fall, w_ncs_rise;
   assign w_sclk_rise = r_sclk_s & ~r_sclk_d;
   assign w_ncs_fall  = ~r_ncs_s & r_ncs_d;
   assign w_ncs_rise  = r_ncs_s & ~r_ncs_d;

   // ------------------------------------------------------- frame capture
   logic [1:0]         r_state;
   logic [c_CNT_W-1:0] r_bit_cnt;
   logic [c_FRAME-1:0] r_shift;

   logic               w_active, w_sample;
   logic [c_CNT_W-1:0] w_cnt_next;
   logic [c_FRAME-1:0] w_shift_next;

   assign w_active = (r_state != c_ST_IDLE);
   assign w_sample = w_active & w_sclk_rise;

   // Post-sample view of the frame. The commit logic looks at these so an
   // SCLK rise landing in the same cycle as the nCS rise is counted first.
   always_comb begin
      w_cnt_next   = r_bit_cnt;
      w_shift_next = r_shift;
      if (w_sample) begin
         if (r_bit_cnt < c_CNT_FRAME) begin
            w_shift_next = {r_shift[c_FRAME-2:0], r_copi_s};
            w_cnt_next   = r_bit_cnt + 1'b1;
         end else begin
            w_cnt_next   = c_CNT_OVF;   // saturate, never wrap
         end
      end
   end

   logic              w_rw, w_to_data, w_commit, w_valid, w_commit_wr, w_commit_err;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_data;

   assign w_rw         = w_shift_next[c_FRAME-1];
   assign w_addr       = w_shift_next[c_FRAME-2 -: ADDR_W];
   assign w_data       = w_shift_next[DATA_W-1:0];
   assign w_to_data    = (r_state == c_ST_CMD) && w_sample && (w_cnt_next == c_CNT_CMD);
   assign w_commit     = w_active & w_ncs_rise;
   assign w_valid      = (w_cnt_next == c_CNT_FRAME);
   assign w_commit_wr  = w_commit & w_valid & w_rw;
   // A select pulse with no SCLK activity is not an error.
   assign w_commit_err = w_commit & ~w_valid & (w_cnt_next != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= c_ST_IDLE;
         r_bit_cnt <= '0;
         r_shift   <= '0;
      end else if (w_commit) begin
         r_state   <= c_ST_IDLE;
         r_bit_cnt <= '0;
         r_shift   <= '0;
      end else if (r_state == c_ST_IDLE) begin
         if (w_ncs_fall) begin
            r_state   <= c_ST_CMD;
            r_bit_cnt <= '0;
            r_shift   <= '0;
         end
      end else begin
         r_bit_cnt <= w_cnt_next;
         r_shift   <= w_shift_next;
         if (w_cnt_next == c_CNT_OVF)
            r_state <= c_ST_OVF;
         else if (w_to_data)
            r_state <= c_ST_DATA;
      end
   end

   // ------------------------------------------------------- register file
   logic [DATA_W-1:0]   r_regs [NUM_REGS];
   logic [NUM_REGS-1:0] r_wr_strobe;
   logic                r_frame_err;
   logic [NUM_REGS-1:0] w_wr_hit;

   // Addresses at or above NUM_REGS match no bit and are dropped silently.
   generate
      for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
         assign w_wr_hit[k] = w_commit_wr && (w_addr == ADDR_W'(k));
         assign reg_out[k*DATA_W +: DATA_W] = r_regs[k];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_strobe <= '0;
         r_frame_err <= 1'b0;
         for (int k = 0; k < NUM_REGS; k++)
            r_regs[k] <= '0;
      end else begin
         r_wr_strobe <= w_wr_hit;
         r_frame_err <= w_commit_err;
         for (int k = 0; k < NUM_REGS; k++)
            if (w_wr_hit[k])
               r_regs[k] <= w_data;
      end
   end

   assign wr_strobe = r_wr_strobe;
   assign frame_err = r_frame_err;

   // ------------------------------------------------------------ readback
`ifdef SPI_READBACK_EN
   logic              w_sclk_fall, w_tx_shift_en;
   logic [ADDR_W-1:0] w_cmd_addr;
   logic [DATA_W-1:0] w_rd_data;
   logic [DATA_W-1:0] r_tx_shift;

   assign w_sclk_fall = ~r_sclk_s & r_sclk_d;
   assign w_cmd_addr  = w_shift_next[ADDR_W-1:0];

   always_comb begin
      w_rd_data = '0;
      for (int k = 0; k < NUM_REGS; k++)
         if (w_cmd_addr == ADDR_W'(k))
            w_rd_data = r_regs[k];
   end

   // The falling edge that closes the last address bit must not shift:
   // the MSB has only just been loaded and is sampled on the next rise.
   assign w_tx_shift_en = w_sclk_fall &&
                          ((r_state == c_ST_DATA) || (r_state == c_ST_OVF)) &&
                          (r_bit_cnt > c_CNT_CMD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_tx_shift <= '0;
      else if (w_ncs_fall || w_commit)
         r_tx_shift <= '0;
      else if (w_to_data)
         r_tx_shift <= w_rd_data;
      else if (w_tx_shift_en)
         r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
   end

   assign CIPO    = r_tx_shift[DATA_W-1];
   assign CIPO_oe = ~r_ncs_s;
`else
   assign CIPO    = 1'b0;
   assign CIPO_oe = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/spi_regfile_peripheral.md
Name: spi_regfile_peripheral

Overview:
Parametrised SPI Mode-0 peripheral that owns a register file of NUM_REGS registers, each DATA_W bits wide. It supports both writes and reads over a single frame format. It strictly checks frame length and flags malformed frames. It replaces fixed 5×8-bit write-only config decoders and feeds the PWM/output-enable logic through a flattened register bus.

Parameters:
NUM_REGS, 5, number of implemented registers (addresses 0..NUM_REGS-1); must be ≤ 2**ADDR_W
ADDR_W, 7, address field width in bits
DATA_W, 8, register/data field width in bits

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
nCS  input  1  chip select, active low, asynchronous to clk
SCLK  input  1  SPI clock, asynchronous to clk, idle low
COPI  input  1  controller-out data, asynchronous to clk
CIPO  output  1  peripheral-out read data
CIPO_oe  output  1  CIPO drive enable (1 while selected)
reg_out  output  NUM_REGS*DATA_W  register file, reg k at bits [k*DATA_W +: DATA_W]
wr_strobe  output  NUM_REGS  one-cycle pulse on bit k when reg k is written
frame_err  output  1  one-cycle pulse when a selected frame is discarded

Behaviour:
- Synchronisation: nCS, SCLK and COPI each pass through a 2-flop synchroniser. nCS sync flops reset to 1; all others reset to 0. Edge detection on synchronised SCLK/nCS uses one extra history flop each.
- Constraint: clk ≥ 8× SCLK frequency.
- Frame format, MSB first, FRAME = 1+ADDR_W+DATA_W bits: bit 0 = R/W (1 = write, 0 = read), then ADDR_W address bits, then DATA_W data bits. COPI is sampled on synchronised SCLK rising edges only.
- FSM states: IDLE, CMD (R/W + address collection), DATA, OVF.
  - IDLE→CMD on nCS_s falling edge; bit counter and shift register are cleared.
  - CMD→DATA after 1+ADDR_W bits have been sampled.
  - DATA→OVF on any SCLK rise after FRAME bits.
  - Any state→IDLE on nCS_s rising edge.
- Commit on nCS_s rising edge. The frame is valid only if exactly FRAME bits were sampled.
  - Valid write with addr < NUM_REGS: reg[addr] ← data on the next clk edge, with wr_strobe[addr]=1 in that same cycle.
  - Valid write with addr ≥ NUM_REGS: silently ignored; no strobe, no error.
  - Valid read: no register change.
  - Invalid frame (bit count ≠ FRAME, including 0 < count < FRAME and OVF): no register change; frame_err=1 for one cycle, in the same cycle a write would have committed.
  - nCS pulse with zero SCLK edges: ignored, no error.
- Simultaneous SCLK rise and nCS rise in the same synchronised cycle: the edge is sampled first, then the commit is evaluated.
- Read path: on the CMD→DATA transition, the output shift register loads reg[addr], or 0 if addr ≥ NUM_REGS.
  - CIPO presents data MSB immediately, within 1 clk of the transition.
  - Each subsequent synchronised SCLK falling edge shifts the next bit out.
  - After DATA_W bits, CIPO=0.
  - During CMD, CIPO=0.
  - CIPO_oe = ~nCS_s.
  - Read data is a snapshot taken at load time; a concurrent internal change does not affect it.
- Reset (async, any time, including mid-frame): all reg_out=0, wr_strobe=0, frame_err=0, CIPO=0, CIPO_oe=0, FSM=IDLE, counters=0. A partially received frame is lost.
- Bit counter width: $clog2(FRAME+2). It saturates in OVF and never wraps.
- Latency: a register update is visible at most 4 clk cycles after the nCS pin rising edge.

Optional Feature:
SPI_READBACK_EN
- Defined: read frames return register contents on CIPO as described above.
- Undefined: the read shift logic is not synthesised; CIPO and CIPO_oe are tied to 0. Read frames are still length-checked: a valid-length read frame is a silent no-op, and a wrong-length read frame pulses frame_err.

Test Plan:
1. Defaults, write frame 1|0x04|0xA5 (16 bits) → reg_out[39:32]=0xA5, wr_strobe=5'b10000 for exactly 1 cycle, frame_err never asserted.
2. Write 0x3C to addr 0x02, then read frame 0|0x02|xx → CIPO shifts 0,0,1,1,1,1,0,0 on the 8 data bits, CIPO_oe=1 only while nCS low, reg_out unchanged.
3. Write to addr 0x05 and to addr 0x7F → no reg change, no strobe, no frame_err. Read of addr 0x05 → CIPO all zeros.
4. 15-bit write frame and 17-bit write frame to addr 0x00 with data 0xFF → reg_out[7:0] stays 0x00, frame_err pulses once per frame.
5. Assert rst_n low after 10 SCLK edges of a write to addr 0x01, release, then send a full write 0x77 to addr 0x01 → reg_out[15:8]=0x77, all other registers 0.
6. Instantiate with NUM_REGS=16, ADDR_W=4, DATA_W=16: 21-bit write 1|0xF|0xBEEF → reg_out[255:240]=0xBEEF, wr_strobe[15] pulses. Read back returns 0xBEEF MSB first.
